// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a 4-phase req/ack handshake carrying a DATA_WIDTH word
// across a clock-domain boundary, with setup delay, per-phase timeout and a transfer counter.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 32,
    parameter int STABLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   xfer_req,
    output logic [DATA_WIDTH-1:0]  xfer_data,
    input  logic                   ack_sync,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    input  logic                   err_clear,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [7:0] SETUP_LOAD = 8'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_RELEASE,
        ST_ERROR
    } state_t;

    state_t                 r_state;
    logic                   r_xfer_req;
    logic [DATA_WIDTH-1:0]  r_xfer_data;
    logic                   r_done;
    logic                   r_timeout_err;
    logic [COUNT_WIDTH-1:0] r_xfer_count;
    logic [7:0]             r_setup_cnt;
    logic [TIMER_W-1:0]     r_timer;

    logic w_ready;
    logic w_accept;
    logic w_timeout;

    // A stale ack from an aborted transfer must drain before a new word may start.
    assign w_ready   = (r_state == ST_IDLE) && !ack_sync;
    assign w_accept  = s_valid && w_ready;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == TIMER_LAST);

    assign s_ready     = w_ready;
    assign busy        = (r_state != ST_IDLE);
    assign xfer_req    = r_xfer_req;
    assign xfer_data   = r_xfer_data;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign xfer_count  = r_xfer_count;

    // NOTE: all state uses non-blocking assignments and a synchronous reset, so every
    // register, including the data hold register, returns to a known value on the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_xfer_req    <= 1'b0;
            r_xfer_data   <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_xfer_count  <= '0;
            r_setup_cnt   <= '0;
            r_timer       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_xfer_data <= s_data;
                        r_timer     <= '0;
                        if (STABLE_CYCLES == 0) begin
                            r_state    <= ST_REQ;
                            r_xfer_req <= 1'b1;
                        end else begin
                            r_setup_cnt <= SETUP_LOAD;
                            r_state     <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_setup_cnt <= r_setup_cnt - 8'd1;
                    if (r_setup_cnt == 8'd1) begin
                        r_state    <= ST_REQ;
                        r_xfer_req <= 1'b1;
                        r_timer    <= '0;
                    end
                end
                ST_REQ: begin
                    // Ack wins over a coincident timeout.
                    if (ack_sync) begin
                        r_state    <= ST_RELEASE;
                        r_xfer_req <= 1'b0;
                        r_timer    <= '0;
                    end else if (w_timeout) begin
                        r_state       <= ST_ERROR;
                        r_xfer_req    <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_sync) begin
                        r_state      <= ST_IDLE;
                        r_done       <= 1'b1;
                        r_xfer_count <= r_xfer_count + 1'b1;
                    end else if (w_timeout) begin
                        r_state       <= ST_ERROR;
                        r_timeout_err <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (err_clear && !ack_sync) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_xfer_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
